// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 32x32 MIPS register file, one sync write port, two async read ports with write-first bypass
module reg_file_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [1:DEPTH-1];
  logic bypass_en;
  always_ff @(posedge clk) begin
    if (reset)
      for (int i = 1; i < DEPTH; i++) regs[i] <= '0;
    else if (we && waddr != '0)
      regs[waddr] <= wdata;
  end
  assign bypass_en = we && !reset;
  always_comb begin
    rdata1 = raddr1 == '0 ? '0 : (bypass_en && waddr == raddr1) ? wdata : regs[raddr1];
    rdata2 = raddr2 == '0 ? '0 : (bypass_en && waddr == raddr2) ? wdata : regs[raddr2];
  end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed plus randomized check of reg_file_2r1w against an array model
module tb_reg_file_2r1w;
  logic        clk = 0;
  logic        reset, we;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata, rdata1, rdata2;
  logic [31:0] model [32];
  int checks = 0;
  int errors = 0;

  reg_file_2r1w dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expect_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we && !reset && waddr == a) return wdata;
    return model[a];
  endfunction

  task automatic apply(input string tag, input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    reset = r; we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
    #1;
    check({tag, ".p1"}, rdata1, expect_read(a1));
    check({tag, ".p2"}, rdata2, expect_read(a2));
    @(posedge clk);
    if (r) foreach (model[i]) model[i] = 32'h0;
    else if (w && wa != 0) model[wa] = wd;
    #1;
  endtask

  initial begin
    foreach (model[i]) model[i] = 32'h0;
    reset = 1; we = 0; waddr = 0; wdata = 0; raddr1 = 0; raddr2 = 0;
    #1;
    apply("rst_wr5", 1, 1, 5, 32'hFFFF_FFFF, 0, 0);
    for (int i = 0; i < 32; i++) begin
      apply("rst_read", 0, 0, 0, 0, 5'(i), 5'(31 - i));
      check("rst_zero", rdata1, 32'h0);
    end
    for (int i = 1; i < 32; i++) apply("wr", 0, 1, 5'(i), 32'hA5A5_0000 + i, 5'(i), 0);
    for (int i = 0; i < 32; i++) begin
      apply("sweep", 0, 0, 0, 0, 5'(i), 5'(31 - i));
      check("sweep_const", rdata1, i == 0 ? 32'h0 : 32'hA5A5_0000 + i);
    end
    apply("r0_wr", 0, 1, 0, 32'hDEAD_BEEF, 0, 0);
    check("r0_wr_const", rdata1, 32'h0);
    apply("r0_after", 0, 0, 0, 0, 0, 0);
    check("r0_after_const", rdata2, 32'h0);
    apply("set7", 0, 1, 7, 32'h1111_1111, 7, 8);
    reset = 0; we = 1; waddr = 7; wdata = 32'h2222_2222; raddr1 = 7; raddr2 = 8;
    #1;
    check("byp_const", rdata1, 32'h2222_2222);
    check("byp_other", rdata2, 32'hA5A5_0008);
    apply("byp", 0, 1, 7, 32'h2222_2222, 7, 8);
    apply("byp_after", 0, 0, 0, 0, 7, 8);
    check("byp_after_const", rdata1, 32'h2222_2222);
    reset = 1; we = 1; waddr = 3; wdata = 32'h3333_3333; raddr1 = 3; raddr2 = 3;
    #1;
    check("rst_nobyp_const", rdata1, 32'hA5A5_0003);
    apply("rst_nobyp", 1, 1, 3, 32'h3333_3333, 3, 3);
    apply("rst_after", 0, 0, 0, 0, 3, 7);
    check("rst_after_const", rdata1, 32'h0);
    reset = 0; we = 1; waddr = 31; wdata = 32'hCAFE_F00D; raddr1 = 31; raddr2 = 31;
    #1;
    check("dual_byp1", rdata1, 32'hCAFE_F00D);
    check("dual_byp2", rdata2, 32'hCAFE_F00D);
    apply("dual", 0, 1, 31, 32'hCAFE_F00D, 31, 31);
    apply("dual_after", 0, 0, 0, 0, 31, 31);
    check("dual_after_const", rdata2, 32'hCAFE_F00D);
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, a1;
      wa = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      apply("rand", $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, wa, $urandom,
            a1, ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
